// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared definitions for the EX-stage ALU control and mul/div engine:
// function codes, ALU select codes, engine state and operation types.
package alu_ctrl_muldiv_pkg;

  // R-type function codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;

  // ALU select codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_t;

  // Encoding matches funct[1:0] of MULT/MULTU/DIV/DIVU
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_t;

endpackage

// File: rtl/alu_ctrl_muldiv_muldiv.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider.
// Ports: clk, rst (async, active high); start/op/a/b launch an operation
// from IDLE; busy while not IDLE; done for the single DONE cycle, during
// which res_hi/res_lo carry the sign-corrected result.
module muldiv_iter
  import alu_ctrl_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_t        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
  logic             neg_q, neg_d;   // negate product or quotient
  logic             rneg_q, rneg_d; // negate remainder
  logic             mul_q, mul_d;

  logic             sgn, is_div, div0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, rem_sh, diff;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    mul_d   = mul_q;
    sgn     = (op == OP_MULT) || (op == OP_DIV);
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    // Divide by zero runs unsigned on raw operands: the restoring loop then
    // yields an all-ones quotient and leaves the dividend as remainder.
    div0    = is_div && (b == '0);
    a_mag   = (sgn && !div0 && a[WIDTH-1]) ? -a : a;
    b_mag   = (sgn && !div0 && b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
    rem_sh  = {acc_q, lo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb_q};

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          count_d = CW'(WIDTH);
          acc_d   = '0;
          neg_d   = sgn && !div0 && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = sgn && !div0 && a[WIDTH-1];
          mul_d   = !is_div;
          if (is_div) begin
            lo_d    = a_mag;
            opb_d   = b_mag;
            state_d = MD_DIV;
          end else begin
            lo_d    = b_mag;
            opb_d   = a_mag;
            state_d = MD_MUL;
          end
        end
      end
      MD_MUL: begin
        acc_d   = sum[WIDTH:1];
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q - 1'b1;
        if (count_d == '0) state_d = MD_DONE;
      end
      MD_DIV: begin
        acc_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        lo_d    = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        count_d = count_q - 1'b1;
        if (count_d == '0) state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = {acc_q, lo_q};
    if (neg_q) prod = -prod;
    if (mul_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_hi = rneg_q ? -acc_q : acc_q;
      res_lo = neg_q ? -lo_q : lo_q;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = (state_q == MD_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mul_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      mul_q   <= mul_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: EX-stage ALU control with HI/LO registers and an
// iterative mul/div engine.
// Ports: clk, rst (async, active high), en (valid EX instruction),
// alu_op/funct (decode), srca/srcb (operands); alu_control, illegal_funct,
// busy, stall, hilo_rdata (MFHI/MFLO read data), hi/lo (architectural).
module alu_ctrl_muldiv
  import alu_ctrl_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic [3:0]         alu_control,
  output logic               illegal_funct,
  output logic               busy,
  output logic               stall,
  output logic [WIDTH-1:0]   hilo_rdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic             rtype, is_md, is_hilo, issue, md_done;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;

  assign rtype = (alu_op == 2'b10);

  always_comb begin
    alu_control   = ALU_ADD;
    illegal_funct = 1'b0;
    is_md         = 1'b0;
    is_hilo       = 1'b0;
    case (funct)
      F_MULT, F_MULTU, F_DIV, F_DIVU: begin is_md = 1'b1; is_hilo = 1'b1; end
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: is_hilo = 1'b1;
      default: ;
    endcase
    if (alu_op == 2'b01) alu_control = ALU_SUB;
    if (rtype) begin
      case (funct)
        F_AND:   alu_control = ALU_AND;
        F_OR:    alu_control = ALU_OR;
        F_XOR:   alu_control = ALU_XOR;
        F_NOR:   alu_control = ALU_NOR;
        F_SLL:   alu_control = ALU_SLL;
        F_SRL:   alu_control = ALU_SRL;
        F_SRA:   alu_control = ALU_SRA;
        F_SLT:   alu_control = ALU_SLT;
        F_ADD:   alu_control = ALU_ADD;
        F_SUB:   alu_control = ALU_SUB;
        default: illegal_funct = !is_hilo;
      endcase
    end
  end

  assign issue = en && rtype && is_md && !busy;
  // DONE counts as busy, so HI/LO readers wait until the result is committed.
  assign stall = en && rtype && is_hilo && busy;

  always_comb begin
    hilo_rdata = '0;
    if (rtype && funct == F_MFHI) hilo_rdata = hi_q;
    if (rtype && funct == F_MFLO) hilo_rdata = lo_q;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_done) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (en && rtype && !busy) begin
      if (funct == F_MTHI) hi_d = srca;
      if (funct == F_MTLO) lo_d = srca;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (issue),
    .op     (md_op_t'(funct[1:0])),
    .a      (srca),
    .b      (srcb),
    .busy   (busy),
    .done   (md_done),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
module tb_alu_ctrl_muldiv;
  import alu_ctrl_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] srca, srcb;
  logic [3:0]  alu_control;
  logic        illegal_funct, busy, stall;
  logic [31:0] hilo_rdata, hi, lo;

  int total = 0;
  int bad   = 0;

  alu_ctrl_muldiv #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst(rst), .en(en), .alu_op(alu_op), .funct(funct),
    .srca(srca), .srcb(srcb), .alu_control(alu_control),
    .illegal_funct(illegal_funct), .busy(busy), .stall(stall),
    .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } md_vec_t;

  dec_vec_t dv[67];
  md_vec_t  mv[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    case (f)
      6'h18: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
      6'h19: begin up = {32'd0, a} * {32'd0, b}; return up; end
      6'h1A: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi_o, output logic [31:0] lo_o,
                        output logic st_o, output int n);
    @(negedge clk);
    en = 1'b1; alu_op = 2'b10; funct = f; srca = a; srcb = b;
    st_o = stall;
    @(posedge clk); #1;
    en = 1'b0; funct = 6'h20;
    wait_idle(n);
    hi_o = hi;
    lo_o = lo;
  endtask

  task automatic set_dec(input int idx, input logic [3:0] c);
    dv[idx].ctrl = c;
    dv[idx].ill  = 1'b0;
  endtask

  logic [31:0] rhi, rlo, ra, rb;
  logic [5:0]  rf;
  logic        rst_st;
  logic [63:0] exp64;
  int          n, nbad;

  initial begin
    // decode expectations
    for (int i = 0; i < 64; i++) dv[i] = '{op: 2'b10, f: 6'(i), ctrl: ALU_ADD, ill: 1'b1};
    set_dec(6'h24, ALU_AND); set_dec(6'h25, ALU_OR);  set_dec(6'h26, ALU_XOR);
    set_dec(6'h27, ALU_NOR); set_dec(6'h00, ALU_SLL); set_dec(6'h02, ALU_SRL);
    set_dec(6'h03, ALU_SRA); set_dec(6'h2A, ALU_SLT); set_dec(6'h20, ALU_ADD);
    set_dec(6'h22, ALU_SUB);
    for (int i = 6'h10; i <= 6'h13; i++) set_dec(i, ALU_ADD);
    for (int i = 6'h18; i <= 6'h1B; i++) set_dec(i, ALU_ADD);
    dv[64] = '{op: 2'b00, f: 6'h22, ctrl: ALU_ADD, ill: 1'b0};
    dv[65] = '{op: 2'b01, f: 6'h20, ctrl: ALU_SUB, ill: 1'b0};
    dv[66] = '{op: 2'b11, f: 6'h3F, ctrl: ALU_ADD, ill: 1'b0};

    mv[0] = '{6'h18, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    mv[1] = '{6'h19, 32'hFFFFFFFD, 32'h7,        32'h00000006, 32'hFFFFFFEB};
    mv[2] = '{6'h1A, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    mv[3] = '{6'h1B, 32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF};
    mv[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mv[5] = '{6'h1A, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    mv[6] = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14};
    mv[7] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    // reset state
    rst = 1'b1; en = 1'b1; alu_op = 2'b10; funct = 6'h12; srca = '0; srcb = '0;
    #12;
    check("rst_state", {busy, stall, hi, lo, hilo_rdata}, '0);
    @(negedge clk); rst = 1'b0; en = 1'b0;

    // decode sweep
    for (int i = 0; i < 67; i++) begin
      alu_op = dv[i].op; funct = dv[i].f;
      #1;
      check($sformatf("dec_op%0d_f%02h", dv[i].op, dv[i].f),
            {alu_control, illegal_funct}, {dv[i].ctrl, dv[i].ill});
    end

    // directed mul/div vectors
    for (int i = 0; i < 8; i++) begin
      run_md(mv[i].f, mv[i].a, mv[i].b, rhi, rlo, rst_st, n);
      check($sformatf("vec%0d_issue_stall", i), rst_st, 1'b0);
      check($sformatf("vec%0d_busy_cycles", i), n, 33);
      check($sformatf("vec%0d_hilo", i), {rhi, rlo}, {mv[i].ehi, mv[i].elo});
    end

    // random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rf = 6'h18 + 6'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      exp64 = model(rf, ra, rb);
      run_md(rf, ra, rb, rhi, rlo, rst_st, n);
      check($sformatf("rnd%0d_f%02h_%h_%h", i, rf, ra, rb), {rhi, rlo}, exp64);
    end

    // MFLO presented through the whole operation
    @(negedge clk);
    en = 1'b1; alu_op = 2'b10; funct = 6'h18; srca = 32'hFFFFFFFD; srcb = 32'h7;
    check("haz_issue_stall", stall, 1'b0);
    @(posedge clk); #1;
    funct = 6'h12;
    nbad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (stall !== 1'b1) nbad++;
    end
    check("haz_mflo_stall_cycles_missing", nbad, 0);
    @(negedge clk);
    check("haz_mflo_release", {stall, hilo_rdata}, {1'b0, 32'hFFFFFFEB});
    en = 1'b0;

    // ADD and MTHI mid-operation
    @(negedge clk);
    en = 1'b1; funct = 6'h18; srca = 32'hFFFFFFFD; srcb = 32'h7;
    @(posedge clk); #1;
    funct = 6'h20; srca = 32'h12345678;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_add", {stall, alu_control}, {1'b0, ALU_ADD});
    @(posedge clk); #1;
    funct = 6'h11;
    @(negedge clk);
    check("mid_mthi_stall", stall, 1'b1);
    @(posedge clk); #1;
    en = 1'b0; funct = 6'h20;
    @(negedge clk);
    check("mid_mthi_no_write", hi, 32'hFFFFFFFF);
    wait_idle(n);
    check("mid_result", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});

    // asynchronous reset during a divide
    @(negedge clk);
    en = 1'b1; funct = 6'h1A; srca = 32'd1000; srcb = 32'd3;
    @(posedge clk); #1;
    funct = 6'h12;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_stall_busy", {busy, stall}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_drop", {busy, stall, hi, lo, hilo_rdata}, '0);
    @(negedge clk); rst = 1'b0; en = 1'b0;
    run_md(6'h1B, 32'd100, 32'd7, rhi, rlo, rst_st, n);
    check("post_rst_divu", {rhi, rlo}, {32'd2, 32'd14});
    check("post_rst_busy_cycles", n, 33);

    // MTLO then MFLO while idle, MTHI then MFHI
    @(negedge clk);
    en = 1'b1; alu_op = 2'b10; funct = 6'h13; srca = 32'hDEADBEEF;
    @(posedge clk); #1;
    funct = 6'h12;
    @(negedge clk);
    check("mtlo_mflo", {stall, hilo_rdata}, {1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    funct = 6'h11; srca = 32'hCAFEF00D;
    @(posedge clk); #1;
    funct = 6'h10;
    @(negedge clk);
    check("mthi_mfhi", {stall, hilo_rdata, lo}, {1'b0, 32'hCAFEF00D, 32'hDEADBEEF});
    // en=0 suppresses MTxx writes
    @(posedge clk); #1;
    en = 1'b0; funct = 6'h13; srca = 32'h0BADF00D;
    @(posedge clk); #1;
    check("en0_no_mtlo", lo, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
